// File: rtl/maquina_pkg.sv
// Shared types for the vending machine: output-stage FSM states, product codes
// and the sale record handed from mealy_fsm to dispensador_salida.
package maquina_pkg;

   typedef enum logic [2:0] {
      IDLE, VEND, PAY_REQ, PAY_REL, FIN, FALLA
   } estado_disp_t;

   localparam logic [1:0] PROD_NINGUNO = 2'b00;
   localparam logic [1:0] PROD_A       = 2'b01;
   localparam logic [1:0] PROD_B       = 2'b10;
   localparam logic [1:0] PROD_C       = 2'b11;

   typedef struct packed {
      logic [1:0] producto;
      logic [1:0] cambio;
   } venta_t;

   function automatic logic [2:0] motor_onehot(input logic [1:0] p);
      case (p)
         PROD_A:  return 3'b001;
         PROD_B:  return 3'b010;
         PROD_C:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter that stops at zero; expira flags the zero state.
// Shared by the motor pulse and the hopper handshake timeout.
module temporizador #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         carga,
   input  logic [W-1:0] valor,
   output logic         expira
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst)             cnt <= '0;
      else if (carga)       cnt <= valor;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign expira = (cnt == '0);

endmodule

// File: rtl/dispensador_salida.sv
// Vending machine output stage: motor pulse, coin-by-coin change payout over a
// four-phase hopper handshake, one-deep pending sale slot, sticky timeout fault.
module dispensador_salida
   import maquina_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int ACK_TIMEOUT  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       listo,
   input  logic [1:0] producto,
   input  logic [1:0] cambio,
   input  logic       hopper_ack,
   output logic [2:0] motor,
   output logic       hopper_req,
   output logic       ocupado,
   output logic       entregado,
   output logic       sobrecarga,
   output logic       falla,
   output logic [1:0] monedas_rest
);

   localparam int MAXC = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1);

   estado_disp_t estado, sig;
   venta_t       entrada, pend, sel;
   logic         pend_vld;
   logic [1:0]   prod_act, prod_sig, mon_sig;
   logic         cargar, dec;
   logic         t_carga, t_exp;
   logic [CW-1:0] t_valor;

   assign entrada = {producto, cambio};

   temporizador #(.W(CW)) u_tmr (
      .clk    (clk),
      .rst    (rst),
      .carga  (t_carga),
      .valor  (t_valor),
      .expira (t_exp)
   );

   always_ff @(posedge clk) begin
      if (!rst) estado <= IDLE;
      else      estado <= sig;
   end

   // The awaited ack level is checked before expiry so a last-cycle ack wins.
   always_comb begin
      sig    = estado;
      cargar = 1'b0;
      dec    = 1'b0;
      sel    = pend_vld ? pend : entrada;
      case (estado)
         IDLE: if (pend_vld || listo) begin
            cargar = 1'b1;
            if (sel.producto != PROD_NINGUNO) sig = VEND;
            else if (sel.cambio != 2'd0)      sig = PAY_REQ;
            else                              sig = FIN;
         end
         VEND:    if (t_exp) sig = (monedas_rest != 2'd0) ? PAY_REQ : FIN;
         PAY_REQ: if (hopper_ack) begin
            dec = 1'b1;
            sig = PAY_REL;
         end else if (t_exp) sig = FALLA;
         PAY_REL: if (!hopper_ack) sig = (monedas_rest != 2'd0) ? PAY_REQ : FIN;
                  else if (t_exp)  sig = FALLA;
         FIN:     sig = IDLE;
         FALLA:   sig = FALLA;
         default: sig = IDLE;
      endcase

      prod_sig = cargar ? sel.producto : prod_act;
      if (sig == FALLA) mon_sig = 2'd0;
      else if (cargar)  mon_sig = sel.cambio;
      else if (dec)     mon_sig = monedas_rest - 2'd1;
      else              mon_sig = monedas_rest;

      t_carga = (sig != estado) && (sig inside {VEND, PAY_REQ, PAY_REL});
      t_valor = (sig == VEND) ? CW'(PULSE_CYCLES - 1) : CW'(ACK_TIMEOUT - 1);
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prod_act     <= PROD_NINGUNO;
         monedas_rest <= 2'd0;
         motor        <= 3'b000;
         hopper_req   <= 1'b0;
         ocupado      <= 1'b0;
         entregado    <= 1'b0;
         falla        <= 1'b0;
         sobrecarga   <= 1'b0;
         pend         <= '0;
         pend_vld     <= 1'b0;
      end else begin
         prod_act     <= prod_sig;
         monedas_rest <= mon_sig;
         motor        <= (sig == VEND) ? motor_onehot(prod_sig) : 3'b000;
         hopper_req   <= (sig == PAY_REQ);
         ocupado      <= (sig != IDLE);
         entregado    <= (sig == FIN);
         falla        <= (sig == FALLA);

         if (sig == FALLA) begin
            pend_vld   <= 1'b0;
            sobrecarga <= 1'b0;
         end else if (estado == IDLE) begin
            // Pending sale is being served; a simultaneous listo refills the slot.
            if (pend_vld) begin
               pend     <= entrada;
               pend_vld <= listo;
            end
         end else if (listo) begin
            if (pend_vld) sobrecarga <= 1'b1;
            else begin
               pend     <= entrada;
               pend_vld <= 1'b1;
            end
         end
      end
   end

endmodule
